// File: rtl/noc_done_monitor.sv
// Per-node start-to-finish latency monitor for the 2x2 mesh, with a global done flag
// and a single-pin serial readout of all eight latency words.
module noc_done_monitor #(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] start_in,
    input  logic [3:0] send_done,
    input  logic [3:0] recv_done,
    input  logic       rd_req,
    output logic       so_data,
    output logic       so_valid,
    output logic       busy,
    output logic       all_done
);

    localparam int NODES = 4;
    localparam int SR_W  = 2 * NODES * CNT_W;
    localparam int BIT_W = $clog2(SR_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SR_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} node_state_t;
    typedef enum logic {R_IDLE, R_SHIFT} rd_state_t;

    logic [NODES-1:0] start_prev_reg;
    logic [NODES-1:0] send_prev_reg;
    logic [NODES-1:0] recv_prev_reg;
    logic [NODES-1:0] start_ev;
    logic [NODES-1:0] send_ev;
    logic [NODES-1:0] recv_ev;
    logic [NODES-1:0] node_done;
    logic [SR_W-1:0]  snap;
    logic             all_done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_prev_reg <= '0;
            send_prev_reg  <= '0;
            recv_prev_reg  <= '0;
        end else begin
            start_prev_reg <= start_in;
            send_prev_reg  <= send_done;
            recv_prev_reg  <= recv_done;
        end
    end

    assign start_ev = start_in & ~start_prev_reg;
    assign send_ev  = send_done & ~send_prev_reg;
    assign recv_ev  = recv_done & ~recv_prev_reg;

    generate
        for (genvar gi = 0; gi < NODES; gi++) begin : g_node
            node_state_t      state_reg, state_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic [CNT_W-1:0] s_lat_reg, s_lat_next;
            logic [CNT_W-1:0] r_lat_reg, r_lat_next;
            logic             s_ok_reg, s_ok_next;
            logic             r_ok_reg, r_ok_next;

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                s_lat_next = s_lat_reg;
                r_lat_next = r_lat_reg;
                s_ok_next  = s_ok_reg;
                r_ok_next  = r_ok_reg;
                // A start edge overrides any done edge seen in the same cycle.
                if (start_ev[gi]) begin
                    state_next = RUN;
                    cnt_next   = CNT_ONE;
                    s_lat_next = '0;
                    r_lat_next = '0;
                    s_ok_next  = 1'b0;
                    r_ok_next  = 1'b0;
                end else if (state_reg == RUN) begin
                    if (cnt_reg != CNT_MAX) begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                    if (send_ev[gi] && !s_ok_reg) begin
                        s_lat_next = cnt_reg;
                        s_ok_next  = 1'b1;
                    end
                    if (recv_ev[gi] && !r_ok_reg) begin
                        r_lat_next = cnt_reg;
                        r_ok_next  = 1'b1;
                    end
                    if (s_ok_next && r_ok_next) begin
                        state_next = DONE;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    s_lat_reg <= '0;
                    r_lat_reg <= '0;
                    s_ok_reg  <= 1'b0;
                    r_ok_reg  <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    s_lat_reg <= s_lat_next;
                    r_lat_reg <= r_lat_next;
                    s_ok_reg  <= s_ok_next;
                    r_ok_reg  <= r_ok_next;
                end
            end

            assign node_done[gi] = (state_reg == DONE);

            // Node gi owns words 2*gi (send) and 2*gi+1 (recv), word 0 at the MSB end.
            assign snap[2*(NODES-gi)*CNT_W-1 -: CNT_W]   = s_ok_reg ? s_lat_reg : '0;
            assign snap[(2*(NODES-gi)-1)*CNT_W-1 -: CNT_W] = r_ok_reg ? r_lat_reg : '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_done_reg <= 1'b0;
        end else begin
            all_done_reg <= &node_done;
        end
    end

    assign all_done = all_done_reg;

    rd_state_t        rd_state_reg, rd_state_next;
    logic [SR_W-1:0]  shift_reg, shift_next;
    logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;

    always_comb begin
        rd_state_next = rd_state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        if (rd_state_reg == R_IDLE) begin
            if (rd_req) begin
                rd_state_next = R_SHIFT;
                shift_next    = snap;
                bit_cnt_next  = '0;
            end
        end else begin
            shift_next   = {shift_reg[SR_W-2:0], 1'b0};
            bit_cnt_next = bit_cnt_reg + BIT_ONE;
            if (bit_cnt_reg == LAST_BIT) begin
                rd_state_next = R_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_reg <= R_IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
        end else begin
            rd_state_reg <= rd_state_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
        end
    end

    assign busy     = (rd_state_reg == R_SHIFT);
    assign so_valid = busy;
    assign so_data  = busy & shift_reg[SR_W-1];

endmodule
